// File: rtl/wishbone_bus_if_pkg.sv
// ==========================================================================
// wishbone_bus_if_pkg: shared bus width, default timeout and state encoding
// Revision: 1.0
// ==========================================================================
`default_nettype none

package wishbone_bus_if_pkg;

  localparam int REG_BUS_W          = 32;
  localparam int WB_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BUSY       = 2'd1,
    ST_WAIT_STALL = 2'd2
  } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/wishbone_bus_if.sv
// ==========================================================================
// wishbone_bus_if: core load/store port to Wishbone B4 classic master bridge
// Revision: 1.0
// ==========================================================================
`default_nettype none

module wishbone_bus_if
  import wishbone_bus_if_pkg::*;
#(
  parameter int unsigned TIMEOUT = WB_TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 cpu_ce_i,
  input  logic                 cpu_we_i,
  input  logic [REG_BUS_W-1:0] cpu_addr_i,
  input  logic [3:0]           cpu_sel_i,
  input  logic [REG_BUS_W-1:0] cpu_data_i,
  output logic [REG_BUS_W-1:0] cpu_data_o,
  output logic                 stallreq_o,
  output logic                 err_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [REG_BUS_W-1:0] wb_adr_o,
  output logic [3:0]           wb_sel_o,
  output logic [REG_BUS_W-1:0] wb_dat_o,
  input  logic [REG_BUS_W-1:0] wb_dat_i,
  input  logic                 wb_ack_i
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  wb_state_t            state;
  wb_state_t            state_nxt;
  logic [7:0]           tmo_cnt;
  logic [REG_BUS_W-1:0] rd_buf;
  logic                 req_go;
  logic                 tmo_hit;

  assign req_go  = cpu_ce_i && !flush_i;
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    case (state)
      ST_IDLE: begin
        stallreq_o = req_go;
        if (req_go) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (flush_i) begin
          state_nxt = ST_IDLE;
        end else if (wb_ack_i) begin
          // Load data is forwarded in the ack cycle so the core loses no cycle.
          cpu_data_o = wb_we_o ? '0 : wb_dat_i;
          state_nxt  = stall_i ? ST_WAIT_STALL : ST_IDLE;
        end else if (tmo_hit) begin
          state_nxt = stall_i ? ST_WAIT_STALL : ST_IDLE;
        end else begin
          stallreq_o = 1'b1;
        end
      end
      ST_WAIT_STALL: begin
        cpu_data_o = rd_buf;
        if (!stall_i || flush_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_sel_o <= '0;
      wb_dat_o <= '0;
      rd_buf   <= '0;
      tmo_cnt  <= '0;
      err_o    <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_go) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= cpu_we_i;
            wb_adr_o <= cpu_addr_i;
            wb_sel_o <= cpu_sel_i;
            wb_dat_o <= cpu_data_i;
            tmo_cnt  <= '0;
          end
        end
        ST_BUSY: begin
          if (flush_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
          end else if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            rd_buf   <= wb_we_o ? '0 : wb_dat_i;
          end else if (tmo_hit) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            err_o    <= 1'b1;
            rd_buf   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wishbone_bus_if.sv
// ==========================================================================
// tb_wishbone_bus_if: directed + randomized check against a transaction model
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_wishbone_bus_if;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0, flush_i = 1'b0, cpu_ce_i = 1'b0, cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0, cpu_data_i = '0, wb_dat_i = '0;
  logic [3:0]  cpu_sel_i = '0;
  logic        wb_ack_i = 1'b0;
  logic [31:0] cpu_data_o, wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        stallreq_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  wishbone_bus_if #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .err_o(err_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: is a transfer outstanding, how old is it, is a
  // result being held for a stalled pipeline, and what the bus lines carry.
  bit          m_busy, m_hold, m_cyc, m_we, m_err;
  int          m_age;
  logic [31:0] m_adr, m_dat, m_rdbuf;
  logic [3:0]  m_sel;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_hold = 0; m_cyc = 0; m_we = 0; m_err = 0; m_age = 0;
      m_adr = '0; m_dat = '0; m_rdbuf = '0; m_sel = '0;
    end else begin
      m_err = 0;
      if (m_busy) begin
        if (flush_i) begin
          m_busy = 0; m_cyc = 0;
        end else if (wb_ack_i) begin
          m_rdbuf = m_we ? 32'h0 : wb_dat_i;
          m_busy = 0; m_cyc = 0; m_we = 0; m_hold = stall_i;
        end else if (m_age == TMO - 1) begin
          m_busy = 0; m_cyc = 0; m_err = 1; m_rdbuf = '0; m_hold = stall_i;
        end else begin
          m_age++;
        end
      end else if (m_hold) begin
        if (!stall_i || flush_i) m_hold = 0;
      end else if (cpu_ce_i && !flush_i) begin
        m_busy = 1; m_age = 0; m_cyc = 1; m_we = cpu_we_i;
        m_adr = cpu_addr_i; m_sel = cpu_sel_i; m_dat = cpu_data_i;
      end
    end
  end

  function automatic logic exp_stallreq();
    if (m_busy) return !flush_i && !wb_ack_i && (m_age != TMO - 1);
    if (m_hold) return 1'b0;
    return cpu_ce_i && !flush_i;
  endfunction

  function automatic logic [31:0] exp_data();
    if (m_busy) return (!flush_i && wb_ack_i && !m_we) ? wb_dat_i : 32'h0;
    if (m_hold) return m_rdbuf;
    return 32'h0;
  endfunction

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("m_cyc", {31'b0, wb_cyc_o}, {31'b0, m_cyc});
      chk("m_stb", {31'b0, wb_stb_o}, {31'b0, m_cyc});
      chk("m_we", {31'b0, wb_we_o}, {31'b0, m_we});
      chk("m_adr", wb_adr_o, m_adr);
      chk("m_sel", {28'b0, wb_sel_o}, {28'b0, m_sel});
      chk("m_dat", wb_dat_o, m_dat);
      chk("m_err", {31'b0, err_o}, {31'b0, m_err});
      chk("m_stallreq", {31'b0, stallreq_o}, {31'b0, exp_stallreq()});
      chk("m_cpu_data", cpu_data_o, exp_data());
    end
  end

  task automatic drive(input logic ce, input logic we, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat,
                       input logic stall, input logic flush, input logic ack,
                       input logic [31:0] rdat);
    @(posedge clk);
    #1;
    cpu_ce_i = ce; cpu_we_i = we; cpu_addr_i = adr; cpu_sel_i = sel;
    cpu_data_i = dat; stall_i = stall; flush_i = flush; wb_ack_i = ack;
    wb_dat_i = rdat;
    #1;
  endtask

  task automatic idle_cycle();
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cyc", {31'b0, wb_cyc_o}, 32'h0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_err", {31'b0, err_o}, 32'h0);
    chk("rst_stallreq", {31'b0, stallreq_o}, 32'h0);
    chk("rst_cpu_data", cpu_data_o, 32'h0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Zero-wait load
    drive(1, 0, 32'h100, 4'hF, 32'h0, 0, 0, 0, 32'h0);
    chk("zw_req_stall", {31'b0, stallreq_o}, 32'h1);
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 1, 32'hDEADBEEF);
    chk("zw_cyc", {31'b0, wb_cyc_o}, 32'h1);
    chk("zw_adr", wb_adr_o, 32'h100);
    chk("zw_ack_stall", {31'b0, stallreq_o}, 32'h0);
    chk("zw_data", cpu_data_o, 32'hDEADBEEF);
    idle_cycle();
    chk("zw_cyc_after", {31'b0, wb_cyc_o}, 32'h0);
    chk("zw_data_after", cpu_data_o, 32'h0);

    // Store, three wait states; ack lands on the last counter value
    drive(1, 1, 32'h200, 4'b0011, 32'h12345678, 0, 0, 0, 32'h0);
    chk("st_req_stall", {31'b0, stallreq_o}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 0, (i == 3), 32'hFFFF0000);
      chk("st_cyc", {31'b0, wb_cyc_o}, 32'h1);
      chk("st_we", {31'b0, wb_we_o}, 32'h1);
      chk("st_sel", {28'b0, wb_sel_o}, 32'h3);
      chk("st_dat", wb_dat_o, 32'h12345678);
      chk("st_stall", {31'b0, stallreq_o}, (i == 3) ? 32'h0 : 32'h1);
      chk("st_cpu_data", cpu_data_o, 32'h0);
    end
    idle_cycle();
    chk("st_cyc_after", {31'b0, wb_cyc_o}, 32'h0);
    chk("st_err_after", {31'b0, err_o}, 32'h0);

    // Load acked while the pipeline is stalled; new request refused meanwhile
    drive(1, 0, 32'h300, 4'hF, 32'h0, 0, 0, 0, 32'h0);
    drive(0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 1, 32'hA5A5A5A5);
    chk("hold_data0", cpu_data_o, 32'hA5A5A5A5);
    drive(1, 0, 32'h999, 4'hF, 32'h0, 1, 0, 0, 32'h0);
    chk("hold_data1", cpu_data_o, 32'hA5A5A5A5);
    chk("hold_noreq", {31'b0, stallreq_o}, 32'h0);
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
    chk("hold_data2", cpu_data_o, 32'hA5A5A5A5);
    chk("hold_nocyc", {31'b0, wb_cyc_o}, 32'h0);
    idle_cycle();
    chk("hold_released", cpu_data_o, 32'h0);

    // Flush in the second busy cycle, then a stray ack
    drive(1, 0, 32'h400, 4'hF, 32'h0, 0, 0, 0, 32'h0);
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 0, 32'h0);
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 1, 32'h11111111);
    chk("fl_cyc", {31'b0, wb_cyc_o}, 32'h0);
    chk("fl_stb", {31'b0, wb_stb_o}, 32'h0);
    chk("fl_err", {31'b0, err_o}, 32'h0);
    chk("fl_stray_data", cpu_data_o, 32'h0);
    idle_cycle();
    chk("fl_cyc_later", {31'b0, wb_cyc_o}, 32'h0);

    // Timeout with no ack
    drive(1, 0, 32'h500, 4'hF, 32'h0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      chk("to_cyc", {31'b0, wb_cyc_o}, 32'h1);
      chk("to_stall", {31'b0, stallreq_o}, (i == 3) ? 32'h0 : 32'h1);
    end
    idle_cycle();
    chk("to_cyc_drop", {31'b0, wb_cyc_o}, 32'h0);
    chk("to_err", {31'b0, err_o}, 32'h1);
    chk("to_data", cpu_data_o, 32'h0);
    idle_cycle();
    chk("to_err_pulse", {31'b0, err_o}, 32'h0);

    // Asynchronous reset in the middle of a transfer
    drive(1, 1, 32'h600, 4'hF, 32'hCAFEF00D, 0, 0, 0, 32'h0);
    idle_cycle();
    chk("ar_cyc_before", {31'b0, wb_cyc_o}, 32'h1);
    rst = 1'b1;
    #1;
    chk("ar_cyc", {31'b0, wb_cyc_o}, 32'h0);
    chk("ar_stb", {31'b0, wb_stb_o}, 32'h0);
    chk("ar_we", {31'b0, wb_we_o}, 32'h0);
    chk("ar_adr", wb_adr_o, 32'h0);
    chk("ar_dat", wb_dat_o, 32'h0);
    chk("ar_stallreq", {31'b0, stallreq_o}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic ack;
      ack = m_cyc ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom,
            4'($urandom), $urandom, $urandom_range(0, 2) == 0,
            $urandom_range(0, 19) == 0, ack, $urandom);
    end

    @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
